avalon_protocol_checker: RTL and testbench

AVALON_PROTOCOL_CHECKER -- requirements
Module: avalon_protocol_checker

---
 rtl/avalon_checker_pkg.sv | 29 ++
 rtl/avalon_read_tracker.sv | 51 +++++
 rtl/avalon_protocol_checker.sv | 176 +++++++++++++++++
 tb/tb_avalon_protocol_checker.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/avalon_checker_pkg.sv
// Shared rule indices, FSM states and helpers for the Avalon-MM protocol checker.
package avalon_checker_pkg;

   localparam int NB_RULES    = 7;
   localparam int R_RDWR      = 0;
   localparam int R_WAITNOREQ = 1;
   localparam int R_DROP      = 2;
   localparam int R_CHANGE    = 3;
   localparam int R_ORPHAN    = 4;
   localparam int R_OVERFLOW  = 5;
   localparam int R_ZEROBURST = 6;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      WR_WAIT,
      WR_BURST
   } state_t;

   function automatic logic [2:0] lowest_rule(input logic [NB_RULES-1:0] v);
      logic [2:0] idx;
      idx = '0;
      for (int i = NB_RULES - 1; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/avalon_read_tracker.sv
// Outstanding read-beat counter with orphan and overflow detection.
module avalon_read_tracker
   import avalon_checker_pkg::*;
#(
   parameter int MAXPENDING = 8,
   parameter int BURSTEN    = 0
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                read,
   input  logic                                waitrequest,
   input  logic                                readdatavalid,
   input  logic [7:0]                          burstcount,
   output logic [$clog2(MAXPENDING+256)-1:0]   outstanding,
   output logic                                orphan,
   output logic                                overflow
);

   localparam int CW = $clog2(MAXPENDING + 256);
   localparam logic [CW:0]   MAXV = {1'b0, {CW{1'b1}}};
   localparam logic [CW-1:0] MAXP = CW'(MAXPENDING);

   logic          accept;
   logic          dec;
   logic [CW:0]   inc;
   logic [CW:0]   sum;
   logic [CW:0]   nxt;

   assign accept   = read & ~waitrequest;
   assign orphan   = readdatavalid & (outstanding == '0);
   assign overflow = outstanding > MAXP;

   // Net change of acceptance and return; an orphan return cannot go below 0.
   always_comb begin
      inc = '0;
      if (accept) begin
         inc = (BURSTEN != 0) ? {{(CW-7){1'b0}}, burstcount}
                              : {{CW{1'b0}}, 1'b1};
      end
      sum = {1'b0, outstanding} + inc;
      dec = readdatavalid & (sum != '0);
      nxt = sum - {{CW{1'b0}}, dec};
      if (nxt > MAXV) nxt = MAXV;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) outstanding <= '0;
      else     outstanding <= nxt[CW-1:0];
   end

endmodule

// File: rtl/avalon_protocol_checker.sv
// Passive Avalon-MM protocol checker: per-rule pulses, sticky flags,
// violation counter and first-error capture.
module avalon_protocol_checker
   import avalon_checker_pkg::*;
#(
   parameter int NBDATABYTES = 2,
   parameter int NBADDRBITS  = 8,
   parameter int MAXPENDING  = 8,
   parameter int BURSTEN     = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NBADDRBITS-1:0]              address,
   input  logic [NBDATABYTES-1:0]             byteenable,
   input  logic [8*NBDATABYTES-1:0]           writedata,
   input  logic                               read,
   input  logic                               write,
   input  logic                               waitrequest,
   input  logic                               readdatavalid,
   input  logic [7:0]                         burstcount,
   input  logic                               enable,
   input  logic                               clear,
   output logic [NB_RULES-1:0]                err_pulse,
   output logic [NB_RULES-1:0]                err_sticky,
   output logic [15:0]                        err_count,
   output logic [2:0]                         first_err_code,
   output logic                               first_err_valid,
   output logic [$clog2(MAXPENDING+256)-1:0]  outstanding
);

   state_t                     state;
   logic [7:0]                 remaining;
   logic [NBADDRBITS-1:0]      prev_address;
   logic [NBDATABYTES-1:0]     prev_byteenable;
   logic [8*NBDATABYTES-1:0]   prev_writedata;
   logic                       hist_valid;

   logic                       orphan;
   logic                       overflow;
   logic                       rd_acc;
   logic                       wr_acc;
   logic                       in_rd_wait;
   logic                       in_wr_wait;
   logic                       addr_chg;
   logic                       data_chg;
   logic                       burst_multi;
   logic [NB_RULES-1:0]        viol;

   avalon_read_tracker #(
      .MAXPENDING (MAXPENDING),
      .BURSTEN    (BURSTEN)
   ) u_read_tracker (
      .clk           (clk),
      .rst           (rst),
      .read          (read),
      .waitrequest   (waitrequest),
      .readdatavalid (readdatavalid),
      .burstcount    (burstcount),
      .outstanding   (outstanding),
      .orphan        (orphan),
      .overflow      (overflow)
   );

   assign rd_acc      = read & ~waitrequest;
   assign wr_acc      = write & ~waitrequest;
   assign in_rd_wait  = hist_valid & (state == RD_WAIT);
   assign in_wr_wait  = hist_valid & (state == WR_WAIT);
   assign addr_chg    = (address != prev_address) |
                        (byteenable != prev_byteenable);
   assign data_chg    = writedata != prev_writedata;
   assign burst_multi = (BURSTEN != 0) & (burstcount > 8'd1);

   always_comb begin
      viol = '0;
      if (enable) begin
         viol[R_RDWR]      = read & write;
         viol[R_WAITNOREQ] = waitrequest & ~read & ~write;
         viol[R_DROP]      = (in_rd_wait & ~read) | (in_wr_wait & ~write);
         viol[R_CHANGE]    = (in_rd_wait & read & addr_chg) |
                             (in_wr_wait & write & (addr_chg | data_chg));
         viol[R_ORPHAN]    = orphan;
         viol[R_OVERFLOW]  = overflow;
         viol[R_ZEROBURST] = (BURSTEN != 0) & (rd_acc | wr_acc) &
                             (burstcount == 8'd0);
      end
   end

   // Transaction tracking runs regardless of enable or clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (read & waitrequest) begin
                  state <= RD_WAIT;
               end else if (write & waitrequest) begin
                  state <= WR_WAIT;
               end else if (wr_acc & burst_multi) begin
                  state     <= WR_BURST;
                  remaining <= burstcount - 8'd1;
               end
            end
            RD_WAIT: begin
               if (!read || !waitrequest) state <= IDLE;
            end
            WR_WAIT: begin
               if (!write) begin
                  state <= IDLE;
               end else if (!waitrequest) begin
                  if (burst_multi) begin
                     state     <= WR_BURST;
                     remaining <= burstcount - 8'd1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            WR_BURST: begin
               if (wr_acc) begin
                  if (remaining <= 8'd1) begin
                     state     <= IDLE;
                     remaining <= '0;
                  end else begin
                     remaining <= remaining - 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_address    <= '0;
         prev_byteenable <= '0;
         prev_writedata  <= '0;
         hist_valid      <= 1'b0;
      end else begin
         prev_address    <= address;
         prev_byteenable <= byteenable;
         prev_writedata  <= writedata;
         hist_valid      <= 1'b1;
      end
   end

   // Clear takes precedence and discards the same-cycle violation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_pulse       <= '0;
         err_sticky      <= '0;
         err_count       <= '0;
         first_err_code  <= '0;
         first_err_valid <= 1'b0;
      end else if (clear) begin
         err_pulse       <= '0;
         err_sticky      <= '0;
         err_count       <= '0;
         first_err_code  <= '0;
         first_err_valid <= 1'b0;
      end else begin
         err_pulse  <= viol;
         err_sticky <= err_sticky | viol;
         if (|viol) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (!first_err_valid) begin
               first_err_valid <= 1'b1;
               first_err_code  <= lowest_rule(viol);
            end
         end
      end
   end

endmodule

// File: tb/tb_avalon_protocol_checker.sv
// Table-driven bench for avalon_protocol_checker (BURSTEN=1, MAXPENDING=8).
module tb_avalon_protocol_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  address = '0;
   logic [1:0]  byteenable = 2'b11;
   logic [15:0] writedata = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic        waitrequest = 1'b0;
   logic        readdatavalid = 1'b0;
   logic [7:0]  burstcount = 8'd1;
   logic        enable = 1'b1;
   logic        clear = 1'b0;
   logic [6:0]  err_pulse;
   logic [6:0]  err_sticky;
   logic [15:0] err_count;
   logic [2:0]  first_err_code;
   logic        first_err_valid;
   logic [8:0]  outstanding;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   avalon_protocol_checker #(
      .NBDATABYTES (2),
      .NBADDRBITS  (8),
      .MAXPENDING  (8),
      .BURSTEN     (1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .address         (address),
      .byteenable      (byteenable),
      .writedata       (writedata),
      .read            (read),
      .write           (write),
      .waitrequest     (waitrequest),
      .readdatavalid   (readdatavalid),
      .burstcount      (burstcount),
      .enable          (enable),
      .clear           (clear),
      .err_pulse       (err_pulse),
      .err_sticky      (err_sticky),
      .err_count       (err_count),
      .first_err_code  (first_err_code),
      .first_err_valid (first_err_valid),
      .outstanding     (outstanding)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic        wt;
      logic        rdv;
      logic [7:0]  addr;
      logic [15:0] wd;
      logic [7:0]  bc;
      logic        en;
      logic        clr;
      logic [6:0]  pulse;
      logic [8:0]  outst;
      logic [15:0] cnt;
      logic [6:0]  sticky;
      logic        fv;
      logic [2:0]  fc;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(
      input logic rd, input logic wr, input logic wt, input logic rdv,
      input logic [7:0] addr, input logic [15:0] wd, input logic [7:0] bc,
      input logic en, input logic clr,
      input logic [6:0] pulse, input logic [8:0] outst,
      input logic [15:0] cnt, input logic [6:0] sticky,
      input logic fv, input logic [2:0] fc);
      vec_t v;
      v.rd = rd; v.wr = wr; v.wt = wt; v.rdv = rdv;
      v.addr = addr; v.wd = wd; v.bc = bc; v.en = en; v.clr = clr;
      v.pulse = pulse; v.outst = outst; v.cnt = cnt;
      v.sticky = sticky; v.fv = fv; v.fc = fc;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic idle_cycle(input logic clr);
      @(negedge clk);
      read = 1'b0; write = 1'b0; waitrequest = 1'b0;
      readdatavalid = 1'b0; clear = clr; enable = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // waited read, accepted, returned
      add(1,0,1,0,8'h20,16'h0,8'd1,1,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      add(1,0,1,0,8'h20,16'h0,8'd1,1,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      add(1,0,1,0,8'h20,16'h0,8'd1,1,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      add(1,0,0,0,8'h20,16'h0,8'd1,1,0, 7'h00,9'd1,16'd0,7'h00,0,3'd0);
      add(0,0,0,1,8'h00,16'h0,8'd1,1,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      add(0,0,0,0,8'h00,16'h0,8'd1,1,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      // read and write together
      add(1,1,0,0,8'h00,16'h0,8'd1,1,0, 7'h01,9'd1,16'd1,7'h01,1,3'd0);
      add(0,0,0,0,8'h00,16'h0,8'd1,1,0, 7'h00,9'd1,16'd1,7'h01,1,3'd0);
      add(0,0,0,1,8'h00,16'h0,8'd1,1,0, 7'h00,9'd0,16'd1,7'h01,1,3'd0);
      add(0,0,0,0,8'h00,16'h0,8'd1,1,1, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      // held write: address change, then drop
      add(0,1,1,0,8'h10,16'hA5A5,8'd1,1,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      add(0,1,1,0,8'h11,16'hA5A5,8'd1,1,0, 7'h08,9'd0,16'd1,7'h08,1,3'd3);
      add(0,0,0,0,8'h11,16'hA5A5,8'd1,1,0, 7'h04,9'd0,16'd2,7'h0C,1,3'd3);
      add(0,0,0,0,8'h00,16'h0,8'd1,1,1, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      // held write: data change
      add(0,1,1,0,8'h10,16'hA5A5,8'd1,1,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      add(0,1,1,0,8'h10,16'h1234,8'd1,1,0, 7'h08,9'd0,16'd1,7'h08,1,3'd3);
      add(0,1,0,0,8'h10,16'h1234,8'd1,1,0, 7'h00,9'd0,16'd1,7'h08,1,3'd3);
      add(0,0,0,0,8'h00,16'h0,8'd1,1,1, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      // waitrequest without request
      add(0,0,1,0,8'h00,16'h0,8'd1,1,0, 7'h02,9'd0,16'd1,7'h02,1,3'd1);
      add(0,0,0,0,8'h00,16'h0,8'd1,1,1, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      // burst read of 4, then orphan return
      add(1,0,0,0,8'h00,16'h0,8'd4,1,0, 7'h00,9'd4,16'd0,7'h00,0,3'd0);
      add(0,0,0,1,8'h00,16'h0,8'd4,1,0, 7'h00,9'd3,16'd0,7'h00,0,3'd0);
      add(0,0,0,1,8'h00,16'h0,8'd4,1,0, 7'h00,9'd2,16'd0,7'h00,0,3'd0);
      add(0,0,0,1,8'h00,16'h0,8'd4,1,0, 7'h00,9'd1,16'd0,7'h00,0,3'd0);
      add(0,0,0,1,8'h00,16'h0,8'd4,1,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      add(0,0,0,1,8'h00,16'h0,8'd4,1,0, 7'h10,9'd0,16'd1,7'h10,1,3'd4);
      add(0,0,0,0,8'h00,16'h0,8'd1,1,1, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      // zero burstcount
      add(1,0,0,0,8'h00,16'h0,8'd0,1,0, 7'h40,9'd0,16'd1,7'h40,1,3'd6);
      add(0,0,0,0,8'h00,16'h0,8'd1,1,1, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      // enable low: tracking only
      add(1,1,0,0,8'h00,16'h0,8'd1,0,0, 7'h00,9'd1,16'd0,7'h00,0,3'd0);
      add(0,0,0,1,8'h00,16'h0,8'd1,0,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      // write burst of 3: drop inside burst is not rule 2
      add(0,1,0,0,8'h30,16'h0,8'd3,1,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      add(0,1,1,0,8'h30,16'h0,8'd3,1,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      add(0,0,0,0,8'h30,16'h0,8'd3,1,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      add(0,1,0,0,8'h30,16'h0,8'd3,1,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      add(0,1,0,0,8'h30,16'h0,8'd3,1,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      add(0,1,1,0,8'h30,16'h0,8'd1,1,0, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      add(0,0,0,0,8'h30,16'h0,8'd1,1,0, 7'h04,9'd0,16'd1,7'h04,1,3'd2);
      add(0,0,0,0,8'h00,16'h0,8'd1,1,1, 7'h00,9'd0,16'd0,7'h00,0,3'd0);
      // three bursts of 4 overflow, then clear beats same-cycle violation
      add(1,0,0,0,8'h00,16'h0,8'd4,1,0, 7'h00,9'd4,16'd0,7'h00,0,3'd0);
      add(1,0,0,0,8'h00,16'h0,8'd4,1,0, 7'h00,9'd8,16'd0,7'h00,0,3'd0);
      add(1,0,0,0,8'h00,16'h0,8'd4,1,0, 7'h00,9'd12,16'd0,7'h00,0,3'd0);
      add(0,0,0,0,8'h00,16'h0,8'd1,1,0, 7'h20,9'd12,16'd1,7'h20,1,3'd5);
      add(0,0,0,0,8'h00,16'h0,8'd1,1,1, 7'h00,9'd12,16'd0,7'h00,0,3'd0);

      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("reset_pulse", 32'(err_pulse), 32'h0);
      chk("reset_sticky", 32'(err_sticky), 32'h0);
      chk("reset_count", 32'(err_count), 32'h0);
      chk("reset_fv", 32'(first_err_valid), 32'h0);
      chk("reset_fc", 32'(first_err_code), 32'h0);
      chk("reset_outst", 32'(outstanding), 32'h0);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         read = tbl[i].rd; write = tbl[i].wr;
         waitrequest = tbl[i].wt; readdatavalid = tbl[i].rdv;
         address = tbl[i].addr; writedata = tbl[i].wd;
         burstcount = tbl[i].bc; enable = tbl[i].en; clear = tbl[i].clr;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_pulse", i), 32'(err_pulse), 32'(tbl[i].pulse));
         chk($sformatf("v%0d_outst", i), 32'(outstanding), 32'(tbl[i].outst));
         chk($sformatf("v%0d_count", i), 32'(err_count), 32'(tbl[i].cnt));
         chk($sformatf("v%0d_sticky", i), 32'(err_sticky), 32'(tbl[i].sticky));
         chk($sformatf("v%0d_fv", i), 32'(first_err_valid), 32'(tbl[i].fv));
         chk($sformatf("v%0d_fc", i), 32'(first_err_code), 32'(tbl[i].fc));
      end

      // Reset mid-read: tracking abandoned, no rule 2 after release.
      @(negedge clk);
      read = 1'b1; waitrequest = 1'b1; clear = 1'b0;
      address = 8'h40; burstcount = 8'd1;
      @(posedge clk);
      #1;
      chk("pre_rst_sticky", 32'(err_sticky), 32'h20);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_outst", 32'(outstanding), 32'h0);
      chk("mid_rst_sticky", 32'(err_sticky), 32'h0);
      chk("mid_rst_count", 32'(err_count), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      read = 1'b0; waitrequest = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_pulse", 32'(err_pulse), 32'h0);
      idle_cycle(1'b0);
      chk("post_rst_sticky", 32'(err_sticky), 32'h0);
      chk("post_rst_fv", 32'(first_err_valid), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
